// File: rtl/window_pkg.sv
// Shared types and helpers for the raster-scan window former.
package window_pkg;

    localparam int unsigned DEF_IMAGE_WIDTH  = 7;
    localparam int unsigned DEF_IMAGE_HEIGHT = 7;
    localparam int unsigned DEF_WINDOW_SIZE  = 3;
    localparam int unsigned ADDR_WIDTH       = $clog2(DEF_IMAGE_WIDTH);
    localparam int unsigned ROW_WIDTH        = $clog2(DEF_IMAGE_HEIGHT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Flat bit position of window element (row r, column c); r=0 is the oldest row.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// n x n window register; each shift moves columns left and loads a new rightmost column.
module window_shift_reg
    import window_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = DEF_WINDOW_SIZE
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_shift,
    input  logic [WINDOW_SIZE-1:0]             i_col_in,
    output logic [WINDOW_SIZE*WINDOW_SIZE-1:0] o_window
);

    localparam int unsigned N = WINDOW_SIZE;

    logic [N*N-1:0] r_win;
    logic [N*N-1:0] w_next;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N - 1; c++) begin : g_col
            assign w_next[win_idx(r, c, N)] = r_win[win_idx(r, c + 1, N)];
        end
        assign w_next[win_idx(r, N - 1, N)] = i_col_in[r];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win <= '0;
        end else if (i_shift) begin
            r_win <= w_next;
        end
    end

    assign o_window = r_win;

endmodule

// File: rtl/window_former.sv
// Raster-scan front end: tracks pixel position, drives the line buffer and emits n x n windows.
module window_former
    import window_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int unsigned WINDOW_SIZE  = DEF_WINDOW_SIZE
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_frame_start,
    input  logic                                i_pixel_valid,
    input  logic                                i_pixel,
    output logic                                o_lb_we_c,
    output logic [$clog2(IMAGE_WIDTH)-1:0]      o_lb_addr_c,
    output logic                                o_lb_data_c,
    input  logic [WINDOW_SIZE-2:0]              i_line_data,
    output logic [WINDOW_SIZE*WINDOW_SIZE-1:0]  o_window,
    output logic                                o_window_valid,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]     o_window_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]      o_window_col,
    output logic                                o_frame_done
);

    localparam int unsigned AW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW = $clog2(IMAGE_HEIGHT);
    localparam int unsigned N  = WINDOW_SIZE;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [AW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [AW-1:0]   w_cur_col;
    logic [RW-1:0]   w_cur_row;
    logic [AW-1:0]   w_col_nxt;
    logic [RW-1:0]   w_row_nxt;
    logic            w_restart;
    logic            w_col_end;
    logic            w_row_end;
    logic            w_last;
    logic            w_win_valid_nxt;
    logic            w_done_nxt;
    logic [N-1:0]    w_col_vec;
    logic            r_window_valid;
    logic            r_frame_done;
    logic [RW-1:0]   r_window_row;
    logic [AW-1:0]   r_window_col;

    // FrameStart relocates the current pixel to (0,0) before anything else uses the position.
    assign w_restart = i_pixel_valid & i_frame_start;
    assign w_cur_col = w_restart ? '0 : r_col;
    assign w_cur_row = w_restart ? '0 : r_row;
    assign w_col_end = (w_cur_col == AW'(IMAGE_WIDTH - 1));
    assign w_row_end = (w_cur_row == RW'(IMAGE_HEIGHT - 1));
    assign w_last    = w_col_end & w_row_end;

    assign o_lb_we_c   = i_pixel_valid;
    assign o_lb_addr_c = w_cur_col;
    assign o_lb_data_c = i_pixel;

    // Live pixel is the newest (bottom) row of the incoming column.
    assign w_col_vec = {i_pixel, i_line_data};

    always_comb begin
        w_col_nxt = w_cur_col + AW'(1);
        w_row_nxt = w_cur_row;
        if (w_col_end) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_end ? '0 : w_cur_row + RW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pixel_valid) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_pixel_valid) w_state_nxt = w_last ? ST_IDLE : ST_RUN;
            ST_RUN:  if (i_pixel_valid && w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_win_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        if (i_pixel_valid) begin
            w_win_valid_nxt = (w_cur_row >= RW'(N - 1)) && (w_cur_col >= AW'(N - 1));
            w_done_nxt      = w_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_window_row   <= '0;
            r_window_col   <= '0;
        end else begin
            r_window_valid <= w_win_valid_nxt;
            r_frame_done   <= w_done_nxt;
            if (w_win_valid_nxt) begin
                r_window_row <= w_cur_row;
                r_window_col <= w_cur_col;
            end
        end
    end

    window_shift_reg #(
        .WINDOW_SIZE (N)
    ) u_shift (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_shift  (i_pixel_valid),
        .i_col_in (w_col_vec),
        .o_window (o_window)
    );

    assign o_window_valid = r_window_valid;
    assign o_frame_done   = r_frame_done;
    assign o_window_row   = r_window_row;
    assign o_window_col   = r_window_col;

endmodule

// File: doc/window_former.md
Name: window_former

Overview:
- Raster-scan front end for the binary-image sliding-window pipeline.
- Accepts a 1-bit pixel stream, tracks row/column position, and drives the line buffer (write enable, column address, write data).
- Combines the line buffer's WindowSize-1 previous-row bits with the live pixel and shifts them into an n×n window register.
- Emits each complete window, with its coordinates, to the downstream kernel.

Parameters:
- ImageWidth, 7, pixels per row; sets the line-buffer depth.
- ImageHeight, 7, rows per frame.
- WindowSize, 3, window edge n; n ≥ 2 and n ≤ min(ImageWidth, ImageHeight).

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- FrameStart  in  1  qualifies the current pixel as (row 0, col 0); ignored unless PixelValid.
- PixelValid  in  1  Pixel is valid this cycle; no backpressure exists.
- Pixel  in  1  binary pixel.
- LbWriteEnable  out  1  line-buffer write enable; combinational.
- LbAddr  out  AddrWidth  line-buffer column address; combinational, equals current column.
- LbData  out  1  line-buffer write data; combinational, equals Pixel.
- LineData  in  n-1  line-buffer read data at LbAddr (asynchronous read). Bit n-2 is row r-1; bit 0 is row r-(n-1).
- Window  out  n*n  window; bit index r*n+c, with r=0 the oldest row and c=0 the leftmost column.
- WindowValid  out  1  one-cycle strobe marking a new valid Window.
- WindowRow  out  RowWidth  row of the window's bottom-right pixel.
- WindowCol  out  AddrWidth  column of the window's bottom-right pixel.
- FrameDone  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (asynchronous, nReset=0):
  - All registers clear: Window=0, WindowValid=0, WindowRow=0, WindowCol=0, FrameDone=0.
  - Column and row counters clear to 0; state goes to IDLE.
  - A reset in mid-frame abandons the frame; no partial outputs follow.
- States:
  - IDLE → RUN on PixelValid (with or without FrameStart).
  - RUN → IDLE on acceptance of pixel (ImageHeight-1, ImageWidth-1). FrameDone is registered high for the following cycle only.
- Accept: a pixel is accepted when PixelValid=1. Cycles with PixelValid=0 change no state, and WindowValid=0 on the following cycle.
- Line-buffer drive on accept:
  - LbWriteEnable=1, LbAddr=col, LbData=Pixel.
  - Otherwise LbWriteEnable=0 and LbAddr holds col.
- Column vector: {Pixel, LineData[n-2:0]} is sampled combinationally in the accept cycle, before the line buffer's write edge.
- Window shift on accept:
  - Window column c takes column c+1 for c < n-1.
  - Column n-1 takes the column vector: row n-1 = Pixel, row k = LineData[k] for k < n-1.
- Counters:
  - col increments per accept and wraps at ImageWidth-1 to 0, incrementing row.
  - row wraps at ImageHeight-1 to 0.
  - FrameStart with PixelValid forces the pixel to (0,0); it restarts the frame from RUN and overrides the normal wrap.
- Valid rule: WindowValid is registered and asserts 1 cycle after accepting a pixel with row ≥ n-1 and col ≥ n-1. WindowRow/WindowCol carry that pixel's row/col.
- Latency: pixel accept → Window/WindowValid is 1 clock.
- Row start: window columns are not flushed at col 0. Stale columns are never exposed, because col < n-1 suppresses WindowValid.
- Simultaneous last pixel and FrameStart on the next cycle: FrameDone pulses and the new frame's (0,0) is accepted in the same cycle.

Decomposition:
- Shared package (window_pkg):
  - AddrWidth = $clog2(ImageWidth).
  - RowWidth = $clog2(ImageHeight).
  - Window-index helper function (r*n+c).
  - State encoding IDLE/RUN.
- Sub-module window_shift_reg: n×n shift array with Shift enable and ColIn[n-1:0]. It handles only the column shifting; counters, state and the valid rule stay in the top.

Test Plan (defaults W=7, H=7, n=3; bench pairs the block with a behavioural async-read line buffer):
- All-ones frame, PixelValid continuous from FrameStart:
  - First WindowValid 1 cycle after pixel index 16 (row 2, col 2), with Window=9'h1FF.
  - Exactly 25 strobes.
  - FrameDone 1 cycle after pixel 48.
- Pixel=(row==col) pattern: the window at (2,2) has Window=9'b100_010_001 (bits 0, 4 and 8 set, r*n+c indexing); the window at (3,2) has Window=9'b000_100_010.
- Random PixelValid gaps (50% duty) on a random frame:
  - Window/WindowRow/WindowCol sequence matches the golden model.
  - No WindowValid follows an idle cycle.
  - LbWriteEnable is asserted only on accepts.
- FrameStart asserted at pixel 20 of the frame:
  - Counters restart at (0,0).
  - No WindowValid until new pixel 16.
  - No FrameDone for the aborted frame.
- nReset pulsed low at pixel 30:
  - All outputs read 0 immediately, state is IDLE.
  - A following full frame matches the golden model.
- Back-to-back frames: the FrameDone pulse coincides with the next FrameStart accept, and the second frame yields 25 correct windows.
